// File: rtl/axi_h266enc_pkg.sv
// rtl/axi_h266enc_pkg.sv - shared register map, bit indices and writer state type
package axi_h266enc_pkg;

  // Register offsets, decoded on address bits [9:0]
  localparam logic [9:0] REG_BASE      = 10'h000;
  localparam logic [9:0] REG_CTRL      = 10'h008;
  localparam logic [9:0] REG_STATUS    = 10'h010;
  localparam logic [9:0] REG_FRAME_IDX = 10'h018;
  localparam logic [9:0] REG_FRAME_CNT = 10'h020;
  localparam logic [9:0] REG_RESULT    = 10'h100;

  // CTRL bits
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLEAR  = 2;

  // STATUS bits
  localparam int STATUS_BUSY  = 0;
  localparam int STATUS_DONE  = 1;
  localparam int STATUS_ERROR = 2;
  localparam int STATUS_BRESP = 4;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} wr_state_e;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;

  // AXI size code for one beat of the given data width (32 or 64 bits)
  function automatic logic [2:0] axi_size(input int data_bits);
    return (data_bits == 64) ? 3'd3 : 3'd2;
  endfunction

endpackage

// File: rtl/axi_burst_writer.sv
// rtl/axi_burst_writer.sv - master FSM writing one latched result vector as an INCR burst
module axi_burst_writer
  import axi_h266enc_pkg::*;
#(
  parameter int DATA_BITS   = 64,
  parameter int NUM_RESULTS = 6,
  parameter int ADDR_BITS   = 32
) (
  input  logic                             s_axi_aclk,
  input  logic                             s_axi_aresetn,
  input  logic                             enable_i,
  input  logic [ADDR_BITS-1:0]             frame_addr_i,
  input  logic                             res_valid_i,
  input  logic [NUM_RESULTS*DATA_BITS-1:0] res_data_i,
  output logic                             res_ready_o,
  output logic [NUM_RESULTS*DATA_BITS-1:0] result_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [1:0]                       bresp_o,
  output logic [ADDR_BITS-1:0]             m_axi_awaddr,
  output logic [7:0]                       m_axi_awlen,
  output logic [2:0]                       m_axi_awsize,
  output logic [1:0]                       m_axi_awburst,
  output logic                             m_axi_awvalid,
  input  logic                             m_axi_awready,
  output logic [DATA_BITS-1:0]             m_axi_wdata,
  output logic [DATA_BITS/8-1:0]           m_axi_wstrb,
  output logic                             m_axi_wlast,
  output logic                             m_axi_wvalid,
  input  logic                             m_axi_wready,
  input  logic [1:0]                       m_axi_bresp,
  input  logic                             m_axi_bvalid,
  output logic                             m_axi_bready
);

  localparam int BEAT_W = 4;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_RESULTS - 1);

  wr_state_e                        state_q, state_d;
  logic [ADDR_BITS-1:0]             awaddr_q, awaddr_d;
  logic                             awvalid_q, awvalid_d;
  logic [DATA_BITS-1:0]             wdata_q, wdata_d;
  logic                             wlast_q, wlast_d;
  logic                             wvalid_q, wvalid_d;
  logic                             bready_q, bready_d;
  logic [BEAT_W-1:0]                beat_q, beat_d;
  logic [NUM_RESULTS*DATA_BITS-1:0] result_q, result_d;
  logic [BEAT_W-1:0]                beat_nxt;
  logic [DATA_BITS-1:0]             word_nxt;

  assign res_ready_o   = (state_q == IDLE) && enable_i;
  assign busy_o        = (state_q != IDLE);
  assign bresp_o       = m_axi_bresp;
  assign result_o      = result_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = 8'(NUM_RESULTS - 1);
  assign m_axi_awsize  = axi_size(DATA_BITS);
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = wlast_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;

  // Next state and next registered channel outputs; the next beat word is preloaded on each handshake
  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    awvalid_d = awvalid_q;
    wdata_d   = wdata_q;
    wlast_d   = wlast_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    beat_d    = beat_q;
    result_d  = result_q;
    done_o    = 1'b0;
    beat_nxt  = beat_q + 1'b1;
    word_nxt  = '0;
    for (int i = 0; i < NUM_RESULTS; i++) begin
      if (beat_nxt == BEAT_W'(i)) word_nxt = result_q[i*DATA_BITS +: DATA_BITS];
    end
    case (state_q)
      IDLE: begin
        if (res_valid_i && enable_i) begin
          result_d  = res_data_i;
          awaddr_d  = frame_addr_i;
          awvalid_d = 1'b1;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (m_axi_awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          beat_d    = '0;
          wdata_d   = result_q[DATA_BITS-1:0];
          wlast_d   = (LAST_BEAT == '0);
          state_d   = DATA;
        end
      end
      DATA: begin
        if (m_axi_wready) begin
          if (wlast_q) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
            state_d  = RESP;
          end else begin
            beat_d  = beat_nxt;
            wdata_d = word_nxt;
            wlast_d = (beat_nxt == LAST_BEAT);
          end
        end
      end
      RESP: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          done_o   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and channel registers; reset abandons any burst in flight
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= IDLE;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wdata_q   <= '0;
      wlast_q   <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      beat_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      awvalid_q <= awvalid_d;
      wdata_q   <= wdata_d;
      wlast_q   <= wlast_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      beat_q    <= beat_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: rtl/axi_ame_result_writer.sv
// rtl/axi_ame_result_writer.sv - control/status slave, frame ring and irq around the burst writer
module axi_ame_result_writer
  import axi_h266enc_pkg::*;
#(
  parameter int DATA_BITS   = 64,
  parameter int NUM_RESULTS = 6,
  parameter int ADDR_BITS   = 32,
  parameter int FRAMES      = 8
) (
  input  logic                             s_axi_aclk,
  input  logic                             s_axi_aresetn,
  input  logic [ADDR_BITS-1:0]             s_axi_awaddr,
  input  logic                             s_axi_awvalid,
  output logic                             s_axi_awready,
  input  logic [DATA_BITS-1:0]             s_axi_wdata,
  input  logic                             s_axi_wvalid,
  output logic                             s_axi_wready,
  output logic                             s_axi_bvalid,
  input  logic                             s_axi_bready,
  input  logic [ADDR_BITS-1:0]             s_axi_araddr,
  input  logic                             s_axi_arvalid,
  output logic                             s_axi_arready,
  output logic [DATA_BITS-1:0]             s_axi_rdata,
  output logic                             s_axi_rvalid,
  input  logic                             s_axi_rready,
  input  logic                             res_valid_i,
  input  logic [NUM_RESULTS*DATA_BITS-1:0] res_data_i,
  output logic                             res_ready_o,
  output logic [ADDR_BITS-1:0]             m_axi_awaddr,
  output logic [7:0]                       m_axi_awlen,
  output logic [2:0]                       m_axi_awsize,
  output logic [1:0]                       m_axi_awburst,
  output logic                             m_axi_awvalid,
  input  logic                             m_axi_awready,
  output logic [DATA_BITS-1:0]             m_axi_wdata,
  output logic [DATA_BITS/8-1:0]           m_axi_wstrb,
  output logic                             m_axi_wlast,
  output logic                             m_axi_wvalid,
  input  logic                             m_axi_wready,
  input  logic [1:0]                       m_axi_bresp,
  input  logic                             m_axi_bvalid,
  output logic                             m_axi_bready,
  output logic                             irq_o
);

  localparam int IDX_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int STRIDE = NUM_RESULTS * (DATA_BITS / 8);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAMES - 1);

  logic [ADDR_BITS-1:0]             base_q, base_d;
  logic                             enable_q, enable_d;
  logic                             irq_en_q, irq_en_d;
  logic                             done_q, done_d;
  logic                             error_q, error_d;
  logic [1:0]                       bresp_q, bresp_d;
  logic [IDX_W-1:0]                 frame_idx_q, frame_idx_d;
  logic [31:0]                      frame_cnt_q, frame_cnt_d;
  logic                             bvalid_q, bvalid_d;
  logic                             rvalid_q, rvalid_d;
  logic [DATA_BITS-1:0]             rdata_q, rdata_d;
  logic [DATA_BITS-1:0]             rd_word;
  logic [ADDR_BITS-1:0]             wdata_addr;
  logic [ADDR_BITS-1:0]             frame_addr;
  logic [NUM_RESULTS*DATA_BITS-1:0] result;
  logic                             wr_fire, rd_fire, busy, wr_done;
  logic [1:0]                       wr_bresp;
  logic [9:0]                       wr_addr, rd_addr;
  logic                             unused_bits;

  assign wr_fire       = s_axi_awvalid && s_axi_wvalid && (!bvalid_q || s_axi_bready);
  assign rd_fire       = s_axi_arvalid && (!rvalid_q || s_axi_rready);
  assign s_axi_awready = wr_fire;
  assign s_axi_wready  = wr_fire;
  assign s_axi_arready = rd_fire;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign wr_addr       = s_axi_awaddr[9:0];
  assign rd_addr       = s_axi_araddr[9:0];
  assign wdata_addr    = ADDR_BITS'(s_axi_wdata);
  assign frame_addr    = base_q + ADDR_BITS'(frame_idx_q) * ADDR_BITS'(STRIDE);
  assign irq_o         = irq_en_q && (done_q || error_q);
  assign unused_bits   = ^{s_axi_awaddr[ADDR_BITS-1:10], s_axi_araddr[ADDR_BITS-1:10]};

  axi_burst_writer #(
    .DATA_BITS  (DATA_BITS),
    .NUM_RESULTS(NUM_RESULTS),
    .ADDR_BITS  (ADDR_BITS)
  ) u_writer (
    .s_axi_aclk   (s_axi_aclk),
    .s_axi_aresetn(s_axi_aresetn),
    .enable_i     (enable_q),
    .frame_addr_i (frame_addr),
    .res_valid_i  (res_valid_i),
    .res_data_i   (res_data_i),
    .res_ready_o  (res_ready_o),
    .result_o     (result),
    .busy_o       (busy),
    .done_o       (wr_done),
    .bresp_o      (wr_bresp),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_awlen  (m_axi_awlen),
    .m_axi_awsize (m_axi_awsize),
    .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wstrb  (m_axi_wstrb),
    .m_axi_wlast  (m_axi_wlast),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_bresp  (m_axi_bresp),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready)
  );

  // Read mux for the register map; unmapped offsets read as zero
  always_comb begin
    rd_word = '0;
    case (rd_addr)
      REG_BASE:      rd_word = DATA_BITS'(base_q);
      REG_CTRL:      rd_word = DATA_BITS'({irq_en_q, enable_q});
      REG_STATUS:    rd_word = DATA_BITS'({bresp_q, 1'b0, error_q, done_q, busy});
      REG_FRAME_IDX: rd_word = DATA_BITS'(frame_idx_q);
      REG_FRAME_CNT: rd_word = DATA_BITS'(frame_cnt_q);
      default: begin
        if (rd_addr[9:8] == REG_RESULT[9:8] && rd_addr[2:0] == 3'b000) begin
          for (int i = 0; i < NUM_RESULTS; i++) begin
            if (rd_addr[7:3] == 5'(i)) rd_word = result[i*DATA_BITS +: DATA_BITS];
          end
        end
      end
    endcase
  end

  // Register writes, slave handshakes and frame completion; a completion set overrides a same-cycle clear
  always_comb begin
    base_d      = base_q;
    enable_d    = enable_q;
    irq_en_d    = irq_en_q;
    done_d      = done_q;
    error_d     = error_q;
    bresp_d     = bresp_q;
    frame_idx_d = frame_idx_q;
    frame_cnt_d = frame_cnt_q;
    bvalid_d    = bvalid_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    if (wr_fire) bvalid_d = 1'b1;
    else if (s_axi_bready) bvalid_d = 1'b0;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
    end else if (s_axi_rready) begin
      rvalid_d = 1'b0;
    end
    if (wr_fire) begin
      case (wr_addr)
        REG_BASE: base_d = {wdata_addr[ADDR_BITS-1:3], 3'b000};
        REG_CTRL: begin
          enable_d = s_axi_wdata[CTRL_ENABLE];
          irq_en_d = s_axi_wdata[CTRL_IRQ_EN];
          if (s_axi_wdata[CTRL_CLEAR]) begin
            done_d  = 1'b0;
            error_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
    if (wr_done) begin
      done_d      = 1'b1;
      bresp_d     = wr_bresp;
      if (wr_bresp != RESP_OKAY) error_d = 1'b1;
      frame_idx_d = (frame_idx_q == LAST_IDX) ? '0 : frame_idx_q + 1'b1;
      frame_cnt_d = frame_cnt_q + 32'd1;
    end
  end

  // Register file and slave channel state
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      base_q      <= '0;
      enable_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      bresp_q     <= '0;
      frame_idx_q <= '0;
      frame_cnt_q <= '0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      base_q      <= base_d;
      enable_q    <= enable_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      error_q     <= error_d;
      bresp_q     <= bresp_d;
      frame_idx_q <= frame_idx_d;
      frame_cnt_q <= frame_cnt_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_ame_result_writer.sv
// tb/tb_axi_ame_result_writer.sv - directed bench for the result writer
module tb_axi_ame_result_writer;

  localparam int DB = 64;
  localparam int NR = 6;
  localparam int AB = 32;
  localparam int FR = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [AB-1:0]    s_awaddr, s_araddr;
  logic             s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic             s_arvalid, s_arready, s_rvalid, s_rready;
  logic [DB-1:0]    s_wdata, s_rdata;
  logic             res_valid, res_ready;
  logic [NR*DB-1:0] res_data;
  logic [AB-1:0]    m_awaddr;
  logic [7:0]       m_awlen;
  logic [2:0]       m_awsize;
  logic [1:0]       m_awburst, m_bresp;
  logic             m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [DB-1:0]    m_wdata;
  logic [DB/8-1:0]  m_wstrb;
  logic             irq;

  axi_ame_result_writer #(.DATA_BITS(DB), .NUM_RESULTS(NR), .ADDR_BITS(AB), .FRAMES(FR)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(resetn),
    .s_axi_awaddr(s_awaddr), .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
    .s_axi_wdata(s_wdata), .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
    .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
    .s_axi_araddr(s_araddr), .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
    .s_axi_rdata(s_rdata), .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
    .res_valid_i(res_valid), .res_data_i(res_data), .res_ready_o(res_ready),
    .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen), .m_axi_awsize(m_awsize),
    .m_axi_awburst(m_awburst), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
    .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
    .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
    .irq_o(irq)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int frame_start = 0;
  logic [63:0] words [NR];
  logic [63:0] rd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic axil_write(input logic [31:0] addr, input logic [63:0] data);
    s_awaddr = addr; s_wdata = data; s_awvalid = 1'b1; s_wvalid = 1'b1;
    for (int i = 0; i < 10 && !s_awready; i++) tick();
    check("axil_awready", s_awready, 1'b1);
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
  endtask

  task automatic axil_read(input logic [31:0] addr, output logic [63:0] data);
    s_araddr = addr; s_arvalid = 1'b1;
    for (int i = 0; i < 10 && !s_arready; i++) tick();
    check("axil_arready", s_arready, 1'b1);
    tick();
    s_arvalid = 1'b0;
    check("axil_rvalid", s_rvalid, 1'b1);
    data = s_rdata;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [63:0] exp_v);
    logic [63:0] v;
    axil_read(addr, v);
    check(tag, v, exp_v);
  endtask

  task automatic set_words(input logic [63:0] seed);
    for (int i = 0; i < NR; i++) words[i] = seed + 64'(i);
  endtask

  task automatic start_frame();
    for (int i = 0; i < NR; i++) res_data[i*DB +: DB] = words[i];
    res_valid = 1'b1;
    for (int i = 0; i < 50 && !res_ready; i++) tick();
    check("res_ready", res_ready, 1'b1);
    frame_start = cyc;
    tick();
    res_valid = 1'b0;
    check("awvalid_latency", m_awvalid, 1'b1);
  endtask

  task automatic aw_phase(input int stall, input logic [31:0] exp_addr);
    check("awaddr", m_awaddr, exp_addr);
    check("awlen", m_awlen, 8'd5);
    check("awsize", m_awsize, 3'd3);
    check("awburst", m_awburst, 2'b01);
    for (int k = 0; k < stall; k++) begin
      m_awready = 1'b0;
      tick();
      check("awvalid_held", m_awvalid, 1'b1);
      check("awaddr_held", m_awaddr, exp_addr);
    end
    m_awready = 1'b1;
    tick();
    m_awready = 1'b0;
  endtask

  task automatic w_phase(input bit toggle);
    int beat = 0;
    bit ph = 1'b0;
    for (int g = 0; g < 64 && beat < NR; g++) begin
      m_wready = toggle ? ph : 1'b1;
      ph = ~ph;
      check("wvalid", m_wvalid, 1'b1);
      check("wdata", m_wdata, words[beat]);
      if (m_wready) begin
        check("wlast", m_wlast, (beat == NR - 1));
        check("wstrb", m_wstrb, 8'hFF);
        beat++;
      end
      tick();
    end
    m_wready = 1'b0;
    check("w_beats", beat, NR);
  endtask

  task automatic b_phase(input logic [1:0] resp);
    check("wvalid_done", m_wvalid, 1'b0);
    check("bready", m_bready, 1'b1);
    m_bvalid = 1'b1; m_bresp = resp;
    tick();
    m_bvalid = 1'b0; m_bresp = 2'b00;
    check("bready_drop", m_bready, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, s_awready, 1'b0);
    check({tag, "_wready"}, s_wready, 1'b0);
    check({tag, "_arready"}, s_arready, 1'b0);
    check({tag, "_bvalid"}, s_bvalid, 1'b0);
    check({tag, "_rvalid"}, s_rvalid, 1'b0);
    check({tag, "_rdata"}, s_rdata, 64'd0);
    check({tag, "_res_ready"}, res_ready, 1'b0);
    check({tag, "_m_awvalid"}, m_awvalid, 1'b0);
    check({tag, "_m_wvalid"}, m_wvalid, 1'b0);
    check({tag, "_m_bready"}, m_bready, 1'b0);
    check({tag, "_irq"}, irq, 1'b0);
  endtask

  initial begin
    s_awaddr = '0; s_araddr = '0; s_awvalid = 0; s_wvalid = 0; s_wdata = '0;
    s_bready = 1'b1; s_arvalid = 0; s_rready = 1'b1;
    res_valid = 0; res_data = '0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 2'b00;
    repeat (3) tick();
    check_reset_outputs("in_reset");
    resetn = 1'b1;
    tick();
    check_reset_outputs("post_reset");

    // single frame, zero-wait
    axil_write(32'h000, 64'h1000_0007);
    read_check("base_low_bits", 32'h000, 64'h1000_0000);
    axil_write(32'h008, 64'h1);
    set_words(64'd1);
    start_frame();
    aw_phase(0, 32'h1000_0000);
    w_phase(1'b0);
    b_phase(2'b00);
    check("frame_cycles", cyc - frame_start, 9);
    check("res_ready_b2b", res_ready, 1'b1);
    read_check("status_done", 32'h010, 64'h02);
    read_check("frame_idx_1", 32'h018, 64'd1);
    read_check("result5", 32'h128, 64'd6);
    read_check("unmapped", 32'h030, 64'd0);

    // ring wrap: eight more frames, the ninth lands back on BASE
    for (int f = 1; f < 9; f++) begin
      set_words(64'h100 * 64'(f));
      start_frame();
      aw_phase(0, 32'h1000_0000 + 32'((f % 8) * 48));
      w_phase(1'b0);
      b_phase(2'b00);
    end
    read_check("frame_cnt_9", 32'h020, 64'd9);
    read_check("frame_idx_wrap", 32'h018, 64'd1);

    // error response with interrupt
    axil_write(32'h008, 64'h7);
    check("irq_cleared", irq, 1'b0);
    set_words(64'hE0);
    start_frame();
    aw_phase(0, 32'h1000_0030);
    w_phase(1'b0);
    b_phase(2'b10);
    check("irq_error", irq, 1'b1);
    read_check("status_err", 32'h010, 64'h26);
    axil_write(32'h008, 64'h7);
    check("irq_after_clear", irq, 1'b0);
    read_check("status_cleared", 32'h010, 64'h20);

    // stalls, BASE change while busy
    axil_write(32'h008, 64'h1);
    set_words(64'hA0);
    start_frame();
    axil_write(32'h000, 64'h2000_0000);
    read_check("status_busy", 32'h010, 64'h21);
    aw_phase(5, 32'h1000_0060);
    w_phase(1'b1);
    b_phase(2'b00);

    // ENABLE cleared mid-burst
    set_words(64'h50);
    start_frame();
    aw_phase(0, 32'h2000_0090);
    axil_write(32'h008, 64'h0);
    res_valid = 1'b1;
    res_data = {NR{64'hDEAD}};
    w_phase(1'b0);
    b_phase(2'b00);
    for (int k = 0; k < 3; k++) begin
      check("disabled_res_ready", res_ready, 1'b0);
      check("disabled_awvalid", m_awvalid, 1'b0);
      tick();
    end
    res_valid = 1'b0;
    read_check("status_disabled", 32'h010, 64'h02);
    read_check("frame_cnt_12", 32'h020, 64'd12);

    // asynchronous reset in the middle of DATA
    axil_write(32'h008, 64'h1);
    set_words(64'h60);
    start_frame();
    aw_phase(0, 32'h2000_00C0);
    m_wready = 1'b1;
    tick();
    m_wready = 1'b0;
    check("mid_burst_wvalid", m_wvalid, 1'b1);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(posedge clk);
    #1 resetn = 1'b1;
    tick();
    read_check("base_after_reset", 32'h000, 64'd0);
    read_check("cnt_after_reset", 32'h020, 64'd0);
    axil_write(32'h000, 64'h3000_0000);
    axil_write(32'h008, 64'h1);
    set_words(64'h70);
    start_frame();
    aw_phase(0, 32'h3000_0000);
    w_phase(1'b0);
    b_phase(2'b00);
    read_check("idx_after_reset_frame", 32'h018, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
